demux_cl_scan: RTL and testbench

Sequential 1-to-8 demultiplexer and deserializer: the receiving end of the 8:1 select path in the mux_cl family. It steers a stream of DW-bit symbols into eight slots, either by an explicit 3-bit slot select or by an internal auto-incrementing pointer. Once all eight slots hold data, it presents the assembled frame on a valid/ready output port. It sits downstream of a mux_cl-style selector and rebuilds the parallel word that the selector serialised.

---
 rtl/demux_cl_scan.sv | 111 +++++++++++
 tb/tb_demux_cl_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_cl_scan.sv
`default_nettype none
// ============================================================================
//  Module   : demux_cl_scan
//  Purpose  : Sequential 1-to-8 demultiplexer / deserializer. Symbols are
//             steered into eight DW-bit slots, either by an explicit slot
//             select or by an auto-incrementing pointer. Once every slot
//             has been written in the current frame, the assembled frame is
//             presented on a valid/ready output port.
//  Ports    :
//    clk        rising-edge clock
//    rst        synchronous reset, active-high
//    din        symbol to store (DW bits)
//    din_sel    target slot when auto=0
//    auto       1: slot taken from the internal pointer, 0: from din_sel
//    din_valid  din / din_sel valid this cycle
//    din_ready  block can accept a symbol this cycle (combinational)
//    out_data   assembled frame, slot k at bits [k*DW +: DW]
//    out_valid  out_data holds a complete frame
//    out_ready  consumer takes the frame this cycle
//    dup_err    one-cycle pulse after an addressed write to an already
//               written slot of the current frame
//  Revision : 1.0  initial release
// ============================================================================
module demux_cl_scan #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   din,
  input  logic [2:0]      din_sel,
  input  logic            auto,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [8*DW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            dup_err
);

  logic [7:0][DW-1:0] slot_q,     slot_d;
  logic [7:0]         wmask_q,    wmask_d;
  logic [2:0]         ptr_q,      ptr_d;
  logic [8*DW-1:0]    out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               dup_err_q,  dup_err_d;

  logic               w_accept;
  logic [2:0]         w_tgt;

  // A full output register blocks input unless it is being drained this
  // very cycle, so a new frame can complete during the handoff.
  assign din_ready = !out_valid_q || out_ready;
  assign w_accept  = din_valid && din_ready;
  assign w_tgt     = auto ? ptr_q : din_sel;

  always_comb begin
    slot_d      = slot_q;
    wmask_d     = wmask_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    dup_err_d   = 1'b0;

    if (w_accept) begin
      slot_d[w_tgt] = din;
      wmask_d       = wmask_q | (8'b1 << w_tgt);
      if (auto) begin
        ptr_d = ptr_q + 3'd1;
      end else begin
        // Overwrite still happens; only the error flag reports it.
        dup_err_d = wmask_q[din_sel];
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Completion wins over the handoff clear and restarts the frame.
    if (w_accept && (&wmask_d)) begin
      out_data_d  = slot_d;
      out_valid_d = 1'b1;
      wmask_d     = 8'h00;
      ptr_d       = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      wmask_q     <= 8'h00;
      ptr_q       <= 3'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      wmask_q     <= wmask_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      dup_err_q   <= dup_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign dup_err   = dup_err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_cl_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_cl_scan
//  Purpose  : Self-checking bench for demux_cl_scan (DW=1). A driver issues
//             directed and random symbols and keeps a frame-level model; the
//             expected frames go into a queue that a separate monitor drains
//             whenever the DUT hands a frame off.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_cl_scan;

  localparam int DW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   din;
  logic [2:0]      din_sel;
  logic            auto;
  logic            din_valid;
  logic            din_ready;
  logic [8*DW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            dup_err;

  demux_cl_scan #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_sel   (din_sel),
    .auto      (auto),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Frame-level reference state
  bit [7:0] m_slots;
  bit [7:0] m_mask;
  int       m_ptr;
  bit       m_valid;
  bit       m_dup;
  bit [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance for one rising edge, using the inputs that were stable
  // across that edge.
  task automatic model_edge();
    bit       ready, acc, hand, compl;
    int       s;
    ready = !m_valid || out_ready;
    acc   = din_valid && ready;
    hand  = m_valid && out_ready;
    compl = 1'b0;
    m_dup = 1'b0;
    if (rst) begin
      m_slots = 8'h00; m_mask = 8'h00; m_ptr = 0; m_valid = 1'b0;
      exp_q.delete();
      return;
    end
    if (acc) begin
      s = auto ? m_ptr : int'(din_sel);
      if (!auto && m_mask[s]) m_dup = 1'b1;
      m_slots[s] = din[0];
      m_mask[s]  = 1'b1;
      if (auto) m_ptr = (m_ptr + 1) % 8;
      if (m_mask == 8'hFF) begin
        exp_q.push_back(m_slots);
        m_mask = 8'h00;
        m_ptr  = 0;
        compl  = 1'b1;
      end
    end
    if (compl)     m_valid = 1'b1;
    else if (hand) m_valid = 1'b0;
  endtask

  task automatic step(input bit v, input bit d, input bit [2:0] sel,
                      input bit a, input bit ordy);
    din_valid = v; din = d; din_sel = sel; auto = a; out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: samples mid-cycle, independent of the driver.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, m_valid);
      chk("din_ready", din_ready, !m_valid || out_ready);
      chk("dup_err",   dup_err,   m_dup);
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  bit [7:0] pat;
  bit [7:0] held;

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0; din_sel = 3'd0; auto = 1'b1; out_ready = 1'b1;
    m_slots = 0; m_mask = 0; m_ptr = 0; m_valid = 0; m_dup = 0;
    @(posedge clk); model_edge(); #1;
    @(posedge clk); model_edge(); #1;
    rst = 1'b0;
    chk("reset out_data", out_data, 8'h00);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset din_ready", din_ready, 1'b1);
    chk("reset dup_err", dup_err, 1'b0);

    // Auto-mode frame
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) step(1, pat[i], 0, 1, 1);
    chk("auto frame valid", out_valid, 1'b1);
    chk("auto frame data", out_data, 8'h4D);
    step(0, 0, 0, 1, 1);
    chk("auto frame one cycle", out_valid, 1'b0);

    // Addressed frame
    for (int i = 7; i >= 0; i--) step(1, i[0], 3'(i), 0, 1);
    chk("addr frame data", out_data, 8'hAA);
    step(0, 0, 0, 0, 1);

    // Backpressure
    for (int i = 0; i < 8; i++) step(1, 1'(i % 3 == 0), 0, 1, 0);
    held = out_data;
    chk("bp valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 0);
      chk("bp din_ready", din_ready, 1'b0);
      chk("bp stable", out_data, held);
    end
    chk("bp frame", held, 8'h49);
    step(1, 1, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 1);
    chk("bp next frame slot0", out_data, 8'h01);
    step(0, 0, 0, 1, 1);

    // Duplicate write
    step(1, 1, 3'd3, 0, 1);
    step(1, 0, 3'd3, 0, 1);
    chk("dup pulse", dup_err, 1'b1);
    step(0, 0, 0, 0, 1);
    chk("dup one cycle", dup_err, 1'b0);
    chk("dup no frame", out_valid, 1'b0);
    for (int i = 0; i < 8; i++) if (i != 3) step(1, 1, 3'(i), 0, 1);
    chk("dup frame", out_data, 8'hF7);
    step(0, 0, 0, 0, 1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
    rst = 1'b1; step(0, 0, 0, 1, 1); rst = 1'b0;
    for (int i = 0; i < 7; i++) step(1, 1, 0, 1, 1);
    chk("rst no early frame", out_valid, 1'b0);
    step(1, 1, 0, 1, 1);
    chk("rst frame", out_data, 8'hFF);
    step(0, 0, 0, 1, 1);

    // Back-to-back frames
    for (int i = 0; i < 16; i++) begin
      step(1, 1'(i / 8), 0, 1, 1);
      chk("b2b ready", din_ready, 1'b1);
      if (i == 7)  chk("b2b frame1", out_data, 8'h00);
      if (i == 15) chk("b2b frame2", out_data, 8'hFF);
    end
    step(0, 0, 0, 1, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    step(0, 0, 0, 1, 1);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
